rtc_bus_ctrl: RTL and testbench
===============================

# rtc_bus_ctrl

Parallel-bus cycle generator for the external multiplexed address/data RTC chip. It sits directly downstream of the date/time change sequencers, such as the date-change block that produces register address 8/9/10 plus RD/WR intent. It turns one request into a complete two-phase bus transaction (address phase, then data phase), with chip-select, strobes, A/D select and tri-state control. It returns read data and a one-cycle completion pulse.

## Interface
Parameters:
- `T_PULSE`, default 10: strobe-low width in clk cycles, legal range 1..255.
- `T_GAP`, default 4: setup and hold width in clk cycles around each strobe, legal range 1..255.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request strobe; sampled only while `busy`=0.
- `rw`  in  1  1 = read, 0 = write; latched with `start`.
- `addr`  in  8  RTC register address; latched with `start`.
- `wdata`  in  8  write data; latched with `start`.
- `rdata`  out  8  last read byte.
- `busy`  out  1  transaction in progress.
- `done`  out  1  one-cycle pulse at transaction end.
- `bcd_err`  out  1  read byte is not valid BCD (see Configuration).
- `cs_n`  out  1  chip select, active low.
- `rd_n`  out  1  read strobe, active low.
- `wr_n`  out  1  write strobe, active low.
- `ad_sel`  out  1  0 = address phase, 1 = data phase.
- `ad_out`  out  8  value driven onto the AD bus.
- `ad_oe`  out  1  1 = drive the AD bus (top-level tri-state enable).
- `ad_in`  in  8  AD bus sampled value.

## Operation
- All outputs are registered. Reset values:
  - `cs_n`=`rd_n`=`wr_n`=1.
  - `ad_sel`=0, `ad_oe`=0, `ad_out`=0.
  - `rdata`=0, `busy`=0, `done`=0, `bcd_err`=0.
- FSM states: IDLE, A_SETUP, A_STB, A_HOLD, D_SETUP, D_STB, D_HOLD, DONE.
- Phase durations:
  - SETUP and HOLD states last `T_GAP` cycles.
  - STB states last `T_PULSE` cycles.
  - DONE lasts 1 cycle.
  - One 8-bit down-counter is reloaded on every state entry.
- IDLE: `start`=1 latches `rw`, `addr` and `wdata`, then moves to A_SETUP.
- A_SETUP, A_STB, A_HOLD:
  - `cs_n`=0, `ad_sel`=0, `ad_oe`=1, `ad_out`=latched addr.
  - `wr_n`=0 only in A_STB.
- D_SETUP, D_STB, D_HOLD, write (`rw`=0):
  - `cs_n`=0, `ad_sel`=1, `ad_oe`=1, `ad_out`=latched wdata.
  - `wr_n`=0 only in D_STB.
- D_SETUP, D_STB, D_HOLD, read (`rw`=1):
  - `cs_n`=0, `ad_sel`=1, `ad_oe`=0, `ad_out`=0.
  - `rd_n`=0 only in D_STB.
  - `ad_in` is captured into `rdata` on the edge that leaves D_STB.
- DONE: `done`=1, `cs_n`=1, `ad_oe`=0, then return to IDLE.
- `rdata` holds its value until the next read completes. Writes never change `rdata`.
- `busy`=1 in every state except IDLE.
- `rd_n` and `wr_n` are never low at the same time. No strobe is ever low while `cs_n`=1.

## Timing
- `start` sampled at edge k: `busy`, `cs_n`=0 and `ad_oe`=1 become valid after edge k.
- With defaults:
  - `wr_n` (address) falls after edge k+4 and rises after edge k+14.
  - Data strobe falls after edge k+22 and rises after edge k+32.
  - `done`=1 during the cycle following edge k+36.
  - `busy` falls after edge k+37.
- General latency from `start` to `done` is 2·(2·`T_GAP`+`T_PULSE`) cycles.
- A new `start` is accepted in the first cycle with `busy`=0 (back-to-back spacing is latency+1).
- Boundary behaviour:
  - `start` while `busy`=1, including during DONE: ignored, not queued.
  - `start` held high: one transaction per IDLE visit.
  - Input changes after acceptance: no effect on the transaction in flight.
  - `reset` mid-transaction: at the next edge all outputs return to reset values and the FSM goes to IDLE. No `done` pulse; `rdata` is cleared.
  - `T_PULSE`=`T_GAP`=1: each state lasts exactly one cycle; latency is 6.

## Configuration
- Macro: `RTC_BUS_BCD_CHK_EN`.
- Defined: on read capture, `bcd_err` is set to 1 when either nibble of `ad_in` is greater than 9, else 0. It holds until the next read completes or reset.
- Not defined: `bcd_err` is constant 0 and no check logic is synthesized. The port remains present.

## Test plan
- Reset, then a write with addr=0x08, wdata=0x17 and defaults:
  - Address phase drives 0x08 with `wr_n` low for 10 cycles.
  - Data phase drives 0x17 with `wr_n` low for 10 cycles.
  - `done` pulses 36 cycles after `start`; `rdata` stays 0.
- Read addr=0x09 with the bench driving `ad_in`=0x26 during D_STB:
  - `ad_oe`=0 throughout the data phase.
  - `rd_n` is low for 10 cycles.
  - `rdata`=0x26 at `done`; `bcd_err`=0.
- Read with `ad_in`=0x3A, macro defined: `bcd_err`=1. Same stimulus without the macro: `bcd_err`=0 and `rdata`=0x3A.
- `start` pulsed at cycles 5 and 20 of a transaction, and again during DONE: exactly one `done`. A `start` in the first cycle with `busy`=0 launches a second transaction.
- `reset` asserted during D_STB of a write: the next cycle shows `cs_n`=`wr_n`=1, `ad_oe`=0, `busy`=0, and no `done` pulse follows.
- `T_PULSE`=1, `T_GAP`=1: `done` arrives 6 cycles after `start`, and strobes are low for exactly 1 cycle.

Source files
------------

// File: rtl/rtc_bus_ctrl_if.sv
// rtl/rtc_bus_ctrl_if.sv - request/response and AD-bus signal bundle for rtc_bus_ctrl
interface rtc_bus_ctrl_if;
    logic       start;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       busy;
    logic       done;
    logic       bcd_err;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       ad_sel;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic [7:0] ad_in;

    modport master (
        output start, rw, addr, wdata, ad_in,
        input  rdata, busy, done, bcd_err, cs_n, rd_n, wr_n, ad_sel, ad_out, ad_oe
    );

    modport slave (
        input  start, rw, addr, wdata, ad_in,
        output rdata, busy, done, bcd_err, cs_n, rd_n, wr_n, ad_sel, ad_out, ad_oe
    );
endinterface

// File: rtl/rtc_bus_ctrl.sv
// rtl/rtc_bus_ctrl.sv - two-phase multiplexed AD bus cycle generator for the RTC chip
// Optional read-data BCD check enabled by defining RTC_BUS_BCD_CHK_EN.
module rtc_bus_ctrl #(
    parameter int T_PULSE = 10,
    parameter int T_GAP   = 4
) (
    input logic          clk,
    input logic          reset,
    rtc_bus_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, A_SETUP, A_STB, A_HOLD, D_SETUP, D_STB, D_HOLD, DONE
    } state_t;

    localparam logic [7:0] PULSE_M1 = 8'(T_PULSE - 1);
    localparam logic [7:0] GAP_M1   = 8'(T_GAP - 1);

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic       lat_rw, rw_v;
    logic [7:0] lat_addr, addr_v, lat_wdata, wdata_v;
    logic       in_a, in_d, capture;

    always_comb begin
        state_n = state;
        rw_v    = lat_rw;
        addr_v  = lat_addr;
        wdata_v = lat_wdata;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = A_SETUP;
                    rw_v    = bus.rw;
                    addr_v  = bus.addr;
                    wdata_v = bus.wdata;
                end
            end
            A_SETUP: if (cnt == 8'd0) state_n = A_STB;
            A_STB:   if (cnt == 8'd0) state_n = A_HOLD;
            A_HOLD:  if (cnt == 8'd0) state_n = D_SETUP;
            D_SETUP: if (cnt == 8'd0) state_n = D_STB;
            D_STB:   if (cnt == 8'd0) state_n = D_HOLD;
            D_HOLD:  if (cnt == 8'd0) state_n = DONE;
            default: state_n = IDLE;
        endcase

        // The counter reloads on every state change and counts down to zero inside a state.
        cnt_n = (cnt != 8'd0) ? cnt - 8'd1 : cnt;
        if (state_n != state) begin
            case (state_n)
                A_STB, D_STB:                    cnt_n = PULSE_M1;
                A_SETUP, A_HOLD, D_SETUP, D_HOLD: cnt_n = GAP_M1;
                default:                         cnt_n = 8'd0;
            endcase
        end

        in_a    = (state_n == A_SETUP) || (state_n == A_STB) || (state_n == A_HOLD);
        in_d    = (state_n == D_SETUP) || (state_n == D_STB) || (state_n == D_HOLD);
        capture = (state == D_STB) && (state_n == D_HOLD) && lat_rw;
    end

`ifdef RTC_BUS_BCD_CHK_EN
    logic bcd_err_q;
    assign bus.bcd_err = bcd_err_q;
`else
    assign bus.bcd_err = 1'b0;
`endif

    // Outputs are decoded from the next state so every pin is a plain register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            lat_rw     <= 1'b0;
            lat_addr   <= 8'd0;
            lat_wdata  <= 8'd0;
            bus.cs_n   <= 1'b1;
            bus.rd_n   <= 1'b1;
            bus.wr_n   <= 1'b1;
            bus.ad_sel <= 1'b0;
            bus.ad_oe  <= 1'b0;
            bus.ad_out <= 8'd0;
            bus.rdata  <= 8'd0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
`ifdef RTC_BUS_BCD_CHK_EN
            bcd_err_q  <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            lat_rw     <= rw_v;
            lat_addr   <= addr_v;
            lat_wdata  <= wdata_v;
            bus.cs_n   <= !(in_a || in_d);
            bus.ad_sel <= in_d;
            bus.ad_oe  <= in_a || (in_d && !rw_v);
            bus.ad_out <= in_a ? addr_v : ((in_d && !rw_v) ? wdata_v : 8'd0);
            bus.wr_n   <= !((state_n == A_STB) || ((state_n == D_STB) && !rw_v));
            bus.rd_n   <= !((state_n == D_STB) && rw_v);
            bus.busy   <= (state_n != IDLE);
            bus.done   <= (state_n == DONE);
            if (capture) begin
                bus.rdata <= bus.ad_in;
`ifdef RTC_BUS_BCD_CHK_EN
                bcd_err_q <= (bus.ad_in[7:4] > 4'd9) || (bus.ad_in[3:0] > 4'd9);
`endif
            end
        end
    end

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// tb/tb_rtc_bus_ctrl.sv - scoreboard bench for rtc_bus_ctrl (default and 1/1 timing builds)
module tb_rtc_bus_ctrl;
    localparam int TP  = 10;
    localparam int TG  = 4;
    localparam int LAT = 2 * (2 * TG + TP);
`ifdef RTC_BUS_BCD_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rtc_bus_ctrl_if b ();
    rtc_bus_ctrl_if b2 ();

    rtc_bus_ctrl #(.T_PULSE(TP), .T_GAP(TG)) dut  (.clk(clk), .reset(reset), .bus(b.slave));
    rtc_bus_ctrl #(.T_PULSE(1),  .T_GAP(1))  dut2 (.clk(clk), .reset(reset), .bus(b2.slave));

    typedef struct {
        int         k;
        logic [7:0] rdata;
        logic       bcd;
    } exp_t;

    exp_t       q[$];
    exp_t       e;
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    logic [7:0] m_rdata = 8'd0;
    logic       m_bcd = 1'b0;
    logic       cur_rw = 1'b0;
    logic [7:0] cur_addr = 8'd0;
    logic [7:0] cur_wdata = 8'd0;
    int         wcnt = 0, rcnt = 0;
    bit         bad = 0, viol = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic bad_bcd(logic [7:0] v);
        return CHK && (((v / 16) > 9) || ((v % 16) > 9));
    endfunction

    // Bus monitor and scoreboard consumer.
    always @(negedge clk) begin
        if (reset) begin
            wcnt = 0; rcnt = 0; bad = 0; viol = 0;
        end else begin
            if (!b.rd_n && !b.wr_n) viol = 1;
            if ((!b.rd_n || !b.wr_n) && b.cs_n) viol = 1;
            if (cur_rw && b.ad_sel && !b.cs_n && b.ad_oe) viol = 1;
            if (!b.wr_n) begin
                wcnt++;
                if (!b.ad_oe || b.ad_out != (b.ad_sel ? cur_wdata : cur_addr)) bad = 1;
            end else if (wcnt != 0) begin
                chk("wr_pulse_width", wcnt, TP);
                chk("wr_bus_value", int'(bad), 0);
                wcnt = 0; bad = 0;
            end
            if (!b.rd_n) begin
                rcnt++;
                if (b.ad_oe || !b.ad_sel) bad = 1;
            end else if (rcnt != 0) begin
                chk("rd_pulse_width", rcnt, TP);
                chk("rd_bus_ctrl", int'(bad), 0);
                rcnt = 0; bad = 0;
            end
            if (b.done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("done_latency", cyc - e.k, LAT);
                    chk("rdata", int'(b.rdata), int'(e.rdata));
                    chk("bcd_err", int'(b.bcd_err), int'(e.bcd));
                    chk("done_cs_oe_busy", int'({b.cs_n, b.ad_oe, b.busy}), 3'b101);
                    chk("protocol", int'(viol), 0);
                    viol = 0;
                end
            end
        end
    end

    task automatic issue(bit rw, logic [7:0] a, logic [7:0] wd, logic [7:0] adin);
        int n = 0;
        while (b.busy && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk("issue_timeout", 1, 0);
        b.start = 1'b1; b.rw = rw; b.addr = a; b.wdata = wd; b.ad_in = adin;
        cur_rw = rw; cur_addr = a; cur_wdata = wd;
        if (rw) begin
            m_rdata = adin;
            m_bcd   = bad_bcd(adin);
        end
        q.push_back('{cyc + 1, m_rdata, m_bcd});
        @(negedge clk);
        b.start = 1'b0;
        b.rw    = 1'($urandom);
        b.addr  = 8'($urandom);
        b.wdata = 8'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((b.busy || q.size() != 0) && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) chk("idle_timeout", 1, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", int'({b.cs_n, b.rd_n, b.wr_n, b.ad_sel, b.ad_oe, b.busy, b.done, b.bcd_err}), 8'b1110_0000);
        chk("reset_ad_out", int'(b.ad_out), 0);
        chk("reset_rdata", int'(b.rdata), 0);
        q.delete();
        m_rdata = 8'd0;
        m_bcd   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run2(bit rw, logic [7:0] a, logic [7:0] wd, logic [7:0] adin);
        int n = 0, wl = 0, rl = 0;
        bit got = 0;
        b2.start = 1'b1; b2.rw = rw; b2.addr = a; b2.wdata = wd; b2.ad_in = adin;
        @(posedge clk);
        while (n < 50 && !got) begin
            @(negedge clk);
            b2.start = 1'b0;
            n++;
            if (!b2.wr_n) wl++;
            if (!b2.rd_n) rl++;
            if (b2.done) got = 1;
        end
        chk("fast_latency", n - 1, 6);
        chk("fast_wr_low", wl, rw ? 1 : 2);
        chk("fast_rd_low", rl, rw ? 1 : 0);
        if (rw) chk("fast_rdata", int'(b2.rdata), int'(adin));
        @(negedge clk);
    endtask

    initial begin
        int n;
        b.start = 0; b.rw = 0; b.addr = 0; b.wdata = 0; b.ad_in = 0;
        b2.start = 0; b2.rw = 0; b2.addr = 0; b2.wdata = 0; b2.ad_in = 0;
        @(negedge clk);
        do_reset();

        issue(1'b0, 8'h08, 8'h17, 8'h00); wait_idle();
        issue(1'b1, 8'h09, 8'h00, 8'h26); wait_idle();
        issue(1'b1, 8'h0A, 8'h00, 8'h3A); wait_idle();

        // Stray starts mid-transaction and during DONE must be dropped.
        issue(1'b0, 8'h10, 8'h55, 8'h00);
        for (int i = 2; i < 80; i++) begin
            @(negedge clk);
            b.start = (i == 5) || (i == 20) || b.done;
            if (b.done) break;
        end
        @(negedge clk);
        b.start = 1'b0;
        chk("start_in_done_ignored", int'(b.busy), 0);
        issue(1'b1, 8'h0C, 8'h00, 8'h47); wait_idle();

        // Reset during the data strobe of a write.
        issue(1'b0, 8'h0B, 8'h42, 8'h00);
        n = 0;
        while (!(b.ad_sel && !b.wr_n) && n < 100) begin @(negedge clk); n++; end
        chk("reach_d_stb", int'(n < 100), 1);
        do_reset();
        repeat (60) @(negedge clk);

        repeat (25) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        end
        wait_idle();

        run2(1'b0, 8'h21, 8'h33, 8'h00);
        run2(1'b1, 8'h22, 8'h00, 8'h59);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
